// File: rtl/aes_dec_pkg.sv
// ---------------------------------------------------------------------------
// aes_dec_pkg
// Shared types, constants and byte-level helpers for the iterative AES-128
// decryption core.
//   byte_t / word_t / block_t : 8/32/128-bit data types (big-endian byte 0
//                               sits in the most significant bits)
//   state_t                   : core FSM states
//   RCON                      : key-schedule round constants, rounds 1..10
//   xtime / gf_mul            : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
//   rcon_of / rot_word        : key-schedule helpers
//   inv_shift_rows / inv_mix_columns : whole-state inverse round transforms
// ---------------------------------------------------------------------------
package aes_dec_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    localparam byte_t RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x, reducing by the AES polynomial.
    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t acc;
        byte_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Out-of-range round numbers yield zero rather than an X lookup.
    function automatic byte_t rcon_of(input logic [3:0] r);
        byte_t v;
        v = '0;
        for (int i = 1; i <= 10; i++) begin
            if (r == 4'(i)) begin
                v = RCON[i];
            end
        end
        return v;
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // State byte n = row + 4*column lives at bits [127-8n -: 8].
    // Row r is rotated right by r positions.
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t o;
        byte_t  a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_composite_dec_if.sv
// ---------------------------------------------------------------------------
// aes_composite_dec_if
// Kin/Din/Krdy/Drdy handshake bundle for the AES-128 decryption core.
//   en        : global enable (low freezes the core)
//   kin/krdy  : cipher key and its one-cycle load strobe
//   kvld      : one-cycle pulse, decryption key ready
//   din/drdy  : ciphertext and its one-cycle strobe
//   dout/dvld : plaintext (held) and its one-cycle valid pulse
//   bsy       : key expansion or decryption in progress
// master drives the requests, slave is the core.
// ---------------------------------------------------------------------------
interface aes_composite_dec_if;
    import aes_dec_pkg::*;

    logic   en;
    block_t kin;
    logic   krdy;
    logic   kvld;
    block_t din;
    logic   drdy;
    block_t dout;
    logic   dvld;
    logic   bsy;

    modport master (
        output en, kin, krdy, din, drdy,
        input  kvld, dout, dvld, bsy
    );

    modport slave (
        input  en, kin, krdy, din, drdy,
        output kvld, dout, dvld, bsy
    );

endinterface

// File: rtl/aes_sbox_cf.sv
// ---------------------------------------------------------------------------
// aes_sbox_cf
// AES S-box with a direction select; both directions share one field
// inverter built around the GF(2^4) subfield of GF(2^8).
//   inv_i : 0 = forward S-box, 1 = inverse S-box
//   a_i   : input byte
//   y_o   : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox_cf
    import aes_dec_pkg::*;
(
    input  logic  inv_i,
    input  byte_t a_i,
    output byte_t y_o
);

    function automatic byte_t affine_fwd(input byte_t x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic byte_t affine_inv(input byte_t x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // x^-1 = x^16 * (x^17)^-1. The norm x^17 lies in the GF(2^4) subfield,
    // where the inverse is y^14 = y^2 * y^4 * y^8. Zero maps to zero
    // because x^16 is zero.
    function automatic byte_t gf_inv(input byte_t x);
        byte_t x2, x4, x8, x16;
        byte_t y, y2, y4, y8, yInv;
        x2   = gf_mul(x, x);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        y    = gf_mul(x16, x);
        y2   = gf_mul(y, y);
        y4   = gf_mul(y2, y2);
        y8   = gf_mul(y4, y4);
        yInv = gf_mul(gf_mul(y2, y4), y8);
        return gf_mul(yInv, x16);
    endfunction

    byte_t invIn;
    byte_t invOut;

    // The inverse direction undoes the affine map before inverting; the
    // forward direction applies it after.
    always_comb begin
        invIn  = inv_i ? affine_inv(a_i) : a_i;
        invOut = gf_inv(invIn);
        y_o    = inv_i ? invOut : affine_fwd(invOut);
    end

endmodule

// File: rtl/aes_composite_dec.sv
// ---------------------------------------------------------------------------
// aes_composite_dec
// Iterative AES-128 decryptor. A loaded key is expanded forward to K10 over
// ten cycles; each block is then decrypted in ten round cycles while the
// schedule is walked backwards from K10 to K0.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : aes_composite_dec_if.slave (en, kin/krdy/kvld, din/drdy/dout/dvld,
//         bsy)
// ---------------------------------------------------------------------------
module aes_composite_dec
    import aes_dec_pkg::*;
(
    input logic               clk,
    input logic               rst,
    aes_composite_dec_if.slave bus
);

    state_t     state_q, state_d;
    logic [3:0] rnd_q, rnd_d;
    logic       keyOk_q, keyOk_d;
    block_t     rk_q, rk_d;
    block_t     k10_q, k10_d;
    block_t     st_q, st_d;
    block_t     dout_q, dout_d;
    logic       dvld_q, dvld_d;
    logic       kvld_q, kvld_d;

    word_t  rk0, rk1, rk2, rk3;
    word_t  p0, p1, p2, p3;
    word_t  sboxWordIn, sboxWordOut, rconWord;
    block_t nextKey, prevKey;
    block_t isrState, isbState, roundXor;

    // Forward key step and backward key step share the four forward
    // S-boxes: KEXP substitutes rk3, DEC substitutes the recovered p3.
    always_comb begin
        rk0 = rk_q[127:96];
        rk1 = rk_q[95:64];
        rk2 = rk_q[63:32];
        rk3 = rk_q[31:0];
        p3  = rk3 ^ rk2;
        p2  = rk2 ^ rk1;
        p1  = rk1 ^ rk0;
        sboxWordIn = (state_q == DEC) ? rot_word(p3) : rot_word(rk3);
        rconWord   = {rcon_of(rnd_q), 24'h000000};
        p0         = rk0 ^ sboxWordOut ^ rconWord;
        prevKey    = {p0, p1, p2, p3};
        nextKey[127:96] = rk0 ^ sboxWordOut ^ rconWord;
        nextKey[95:64]  = rk1 ^ nextKey[127:96];
        nextKey[63:32]  = rk2 ^ nextKey[95:64];
        nextKey[31:0]   = rk3 ^ nextKey[63:32];
    end

    for (genvar i = 0; i < 4; i++) begin : g_key_sbox
        aes_sbox_cf u_sbox (
            .inv_i (1'b0),
            .a_i   (sboxWordIn[31 - 8*i -: 8]),
            .y_o   (sboxWordOut[31 - 8*i -: 8])
        );
    end

    assign isrState = inv_shift_rows(st_q);

    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        aes_sbox_cf u_sbox (
            .inv_i (1'b1),
            .a_i   (isrState[127 - 8*i -: 8]),
            .y_o   (isbState[127 - 8*i -: 8])
        );
    end

    assign roundXor = isbState ^ prevKey;

    // Next-state logic. With en low every register, including the output
    // pulses, holds its value.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        keyOk_d = keyOk_q;
        rk_d    = rk_q;
        k10_d   = k10_q;
        st_d    = st_q;
        dout_d  = dout_q;
        dvld_d  = dvld_q;
        kvld_d  = kvld_q;
        if (bus.en) begin
            dvld_d = 1'b0;
            kvld_d = 1'b0;
            case (state_q)
                IDLE: begin
                    // A key load takes priority and revokes the old key.
                    if (bus.krdy) begin
                        rk_d    = bus.kin;
                        rnd_d   = 4'd1;
                        keyOk_d = 1'b0;
                        state_d = KEXP;
                    end else if (bus.drdy && keyOk_q) begin
                        st_d    = bus.din ^ k10_q;
                        rk_d    = k10_q;
                        rnd_d   = LAST_ROUND;
                        state_d = DEC;
                    end
                end
                KEXP: begin
                    rk_d  = nextKey;
                    rnd_d = rnd_q + 4'd1;
                    if (rnd_q == LAST_ROUND) begin
                        k10_d   = nextKey;
                        keyOk_d = 1'b1;
                        kvld_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                DEC: begin
                    rk_d  = prevKey;
                    rnd_d = rnd_q - 4'd1;
                    // The final round has no InvMixColumns.
                    if (rnd_q == 4'd1) begin
                        dout_d  = roundXor;
                        dvld_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        st_d = inv_mix_columns(roundXor);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            keyOk_q <= 1'b0;
            rk_q    <= '0;
            k10_q   <= '0;
            st_q    <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            kvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            keyOk_q <= keyOk_d;
            rk_q    <= rk_d;
            k10_q   <= k10_d;
            st_q    <= st_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            kvld_q  <= kvld_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.dvld = dvld_q;
    assign bus.kvld = kvld_q;
    assign bus.bsy  = (state_q != IDLE);

endmodule

// File: tb/tb_aes_composite_dec.sv
// ---------------------------------------------------------------------------
// tb_aes_composite_dec
// Directed known-answer bench for aes_composite_dec using the FIPS-197 C.1
// and SP 800-38A ECB vectors, plus handshake corner cases: strobes without
// a key or while busy, simultaneous strobes, enable stalls and mid-block
// reset.
// ---------------------------------------------------------------------------
module tb_aes_composite_dec;
    import aes_dec_pkg::*;

    localparam block_t C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam block_t C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam block_t C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam block_t C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam block_t SP_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t SP_CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam block_t SP_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam block_t SP_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    aes_composite_dec_if bus ();

    aes_composite_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input block_t observed, input block_t expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic doKey, input block_t key, input logic doData, input block_t data);
        bus.kin  = key;
        bus.krdy = doKey;
        bus.din  = data;
        bus.drdy = doData;
        tick();
        bus.krdy = 1'b0;
        bus.drdy = 1'b0;
    endtask

    task automatic waitFor(input bit forKey, output int cycles, output int dvldSeen);
        cycles   = 0;
        dvldSeen = 0;
        while (((forKey ? bus.kvld : bus.dvld) !== 1'b1) && cycles < 40) begin
            tick();
            cycles++;
            if (bus.dvld === 1'b1) dvldSeen++;
        end
    endtask

    task automatic countPulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.dvld === 1'b1) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int seen;
        int more;

        checkCount = 0;
        errorCount = 0;
        rst      = 1'b1;
        bus.en   = 1'b1;
        bus.kin  = '0;
        bus.krdy = 1'b0;
        bus.din  = '0;
        bus.drdy = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("rstDout", bus.dout, '0);
        checkOutput("rstDvld", block_t'(bus.dvld), '0);
        checkOutput("rstKvld", block_t'(bus.kvld), '0);
        checkOutput("rstBsy", block_t'(bus.bsy), '0);

        $display("[TB] Drdy before any key");
        applyStimulus(1'b0, '0, 1'b1, C1_CT);
        checkOutput("noKeyBsy", block_t'(bus.bsy), '0);
        countPulses(15, n);
        checkOutput("noKeyDvld", block_t'(n), '0);
        checkOutput("noKeyDout", bus.dout, '0);

        $display("[TB] FIPS-197 C.1 key load and decrypt");
        applyStimulus(1'b1, C1_KEY, 1'b0, '0);
        checkOutput("kexpBsy", block_t'(bus.bsy), 128'd1);
        waitFor(1'b1, n, seen);
        checkOutput("c1KvldLatency", block_t'(n), 128'd10);
        checkOutput("c1K10", dut.k10_q, C1_K10);
        tick();
        checkOutput("c1KvldPulse", block_t'(bus.kvld), '0);
        applyStimulus(1'b0, '0, 1'b1, C1_CT);
        waitFor(1'b0, n, seen);
        checkOutput("c1DvldLatency", block_t'(n), 128'd10);
        checkOutput("c1Dout", bus.dout, C1_PT);
        tick();
        checkOutput("c1DvldPulse", block_t'(bus.dvld), '0);
        checkOutput("c1BsyDone", block_t'(bus.bsy), '0);

        $display("[TB] Drdy while busy");
        applyStimulus(1'b0, '0, 1'b1, C1_CT);
        repeat (3) tick();
        applyStimulus(1'b0, '0, 1'b1, SP_CT);
        countPulses(20, n);
        checkOutput("busyDvldCount", block_t'(n), 128'd1);
        checkOutput("busyDout", bus.dout, C1_PT);

        $display("[TB] Krdy and Drdy together");
        applyStimulus(1'b1, SP_KEY, 1'b1, SP_CT);
        waitFor(1'b1, n, seen);
        checkOutput("bothKvldLatency", block_t'(n), 128'd10);
        countPulses(12, more);
        checkOutput("bothNoDvld", block_t'(seen + more), '0);
        checkOutput("bothDoutHeld", bus.dout, C1_PT);
        checkOutput("spK10", dut.k10_q, SP_K10);

        $display("[TB] SP 800-38A decrypt with enable stall");
        applyStimulus(1'b0, '0, 1'b1, SP_CT);
        repeat (4) tick();
        bus.en = 1'b0;
        repeat (5) tick();
        bus.en = 1'b1;
        waitFor(1'b0, n, seen);
        checkOutput("stallLatency", block_t'(n + 9), 128'd15);
        checkOutput("stallDout", bus.dout, SP_PT);
        bus.en = 1'b0;
        repeat (2) tick();
        checkOutput("dvldHeldEnLow", block_t'(bus.dvld), 128'd1);
        bus.en = 1'b1;
        tick();
        checkOutput("dvldClearEnHigh", block_t'(bus.dvld), '0);

        $display("[TB] back-to-back blocks");
        applyStimulus(1'b1, C1_KEY, 1'b0, '0);
        waitFor(1'b1, n, seen);
        checkOutput("b2bKvldLatency", block_t'(n), 128'd10);
        tick();
        checkOutput("b2bKvldPulse", block_t'(bus.kvld), '0);
        applyStimulus(1'b0, '0, 1'b1, C1_CT);
        waitFor(1'b0, n, seen);
        checkOutput("b2bFirstLatency", block_t'(n), 128'd10);
        checkOutput("b2bFirstDout", bus.dout, C1_PT);
        applyStimulus(1'b0, '0, 1'b1, C1_CT);
        checkOutput("b2bDvldPulse", block_t'(bus.dvld), '0);
        checkOutput("b2bAccepted", block_t'(bus.bsy), 128'd1);
        waitFor(1'b0, n, seen);
        checkOutput("b2bSecondLatency", block_t'(n), 128'd10);
        checkOutput("b2bSecondDout", bus.dout, C1_PT);
        tick();
        applyStimulus(1'b1, SP_KEY, 1'b0, '0);
        waitFor(1'b1, n, seen);
        checkOutput("b2bSpKvldLatency", block_t'(n), 128'd10);
        tick();
        applyStimulus(1'b0, '0, 1'b1, SP_CT);
        waitFor(1'b0, n, seen);
        checkOutput("b2bSpLatency", block_t'(n), 128'd10);
        checkOutput("b2bSpDout", bus.dout, SP_PT);
        tick();

        $display("[TB] reset mid-decrypt");
        applyStimulus(1'b0, '0, 1'b1, SP_CT);
        repeat (6) tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstDout", bus.dout, '0);
        checkOutput("midRstDvld", block_t'(bus.dvld), '0);
        checkOutput("midRstKvld", block_t'(bus.kvld), '0);
        checkOutput("midRstBsy", block_t'(bus.bsy), '0);
        #1 rst = 1'b0;
        tick();
        applyStimulus(1'b0, '0, 1'b1, SP_CT);
        checkOutput("postRstBsy", block_t'(bus.bsy), '0);
        countPulses(15, n);
        checkOutput("postRstNoDvld", block_t'(n), '0);
        checkOutput("postRstDout", bus.dout, '0);

        $display("[TB] recovery after reset");
        applyStimulus(1'b1, SP_KEY, 1'b0, '0);
        waitFor(1'b1, n, seen);
        checkOutput("recKvldLatency", block_t'(n), 128'd10);
        tick();
        applyStimulus(1'b0, '0, 1'b1, SP_CT);
        waitFor(1'b0, n, seen);
        checkOutput("recDout", bus.dout, SP_PT);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
